icache_fill_ctrl: RTL and testbench

//  Miss-fill controller between the fetch stage and multi-cycle main memory.
//  - On an I-cache miss it stalls fetch and streams one 16-byte block (8 words) from pipelined memory.
//  - It writes each returned word into the cache data array, then writes the tag.
//  - Its outputs feed the cache arrays; instruction memory behind the PC becomes cache plus this FSM.

---
 rtl/cache_pkg.sv | 19 +
 rtl/fill_counter.sv | 21 ++
 rtl/icache_fill_ctrl.sv | 104 ++++++++++
 tb/tb_icache_fill_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants and state type for the I-cache miss-fill controller.
package cache_pkg;

    localparam int WORDS_PER_BLK = 8;
    localparam int BLK_BYTES     = 2 * WORDS_PER_BLK;
    localparam int MEM_LAT       = 4;
    localparam int WSEL_W        = $clog2(WORDS_PER_BLK);
    // One extra bit so a counter can hold WORDS_PER_BLK itself (request saturation point).
    localparam int CNT_W         = WSEL_W + 1;
    localparam int OFF_W         = $clog2(BLK_BYTES);
    localparam int DRAIN_W       = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        DRAIN,
        IDLE,
        FILL
    } fill_state_t;

endpackage

// File: rtl/fill_counter.sv
// Word counter used for both request issue and return tracking within one block fill.
module fill_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    // Clear wins over increment so a fill always starts counting from word 0.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/icache_fill_ctrl.sv
// Miss-fill controller: stalls fetch on an I-cache miss, streams one block from
// pipelined main memory into the data array, then writes the tag.
module icache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              fsm_busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              write_data_arr,
    output logic [WSEL_W-1:0] word_sel,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_arr
);

    fill_state_t        state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [ADDR_W-1:0]  base;
    logic [CNT_W-1:0]   req_cnt;
    logic [CNT_W-1:0]   rcv_cnt;
    logic               in_fill;
    logic               last_word;
    logic               cnt_clr;
    logic               unused_addr_bits;

    // Offset bits of the miss address never matter: the fill always starts at word 0.
    assign unused_addr_bits = ^miss_addr[OFF_W-1:0];

    // Gating with rst_n keeps every enable low during the reset cycle itself,
    // even if the state register still says FILL.
    assign in_fill   = rst_n && (state == FILL);
    assign last_word = (rcv_cnt == CNT_W'(WORDS_PER_BLK - 1));
    assign cnt_clr   = write_tag_arr || (state != FILL);

    // Request side and write side of the fill, decoded from state and counters.
    always_comb begin
        fsm_busy       = !rst_n || (state != IDLE) || miss_detected;
        mem_en         = in_fill && (req_cnt < CNT_W'(WORDS_PER_BLK));
        mem_addr       = base + ADDR_W'({req_cnt, 1'b0});
        write_data_arr = in_fill && mem_data_valid;
        word_sel       = rcv_cnt[WSEL_W-1:0];
        fill_data      = mem_data;
        write_tag_arr  = write_data_arr && last_word;
    end

    fill_counter #(.WIDTH(CNT_W)) u_req_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (mem_en),
        .cnt   (req_cnt)
    );

    fill_counter #(.WIDTH(CNT_W)) u_rcv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (write_data_arr),
        .cnt   (rcv_cnt)
    );

    // Fill sequencing; after reset, DRAIN waits out returns from an aborted fill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_W'(MEM_LAT);
            base      <= '0;
        end else begin
            case (state)
                DRAIN: begin
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                    if (drain_cnt <= DRAIN_W'(1)) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (miss_detected) begin
                        base  <= {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (write_tag_arr) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= DRAIN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: pipelined memory model plus a per-cycle scoreboard.
module tb_icache_fill_ctrl;
    import cache_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_addr;
    logic              fsm_busy;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_data;
    logic              write_data_arr;
    logic [WSEL_W-1:0] word_sel;
    logic [DATA_W-1:0] fill_data;
    logic              write_tag_arr;

    always #5 clk = ~clk;

    icache_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .miss_detected  (miss_detected),
        .miss_addr      (miss_addr),
        .fsm_busy       (fsm_busy),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .write_data_arr (write_data_arr),
        .word_sel       (word_sel),
        .fill_data      (fill_data),
        .write_tag_arr  (write_tag_arr)
    );

    typedef struct {
        logic [15:0] addr;
        int          due;
    } req_t;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] base;
        int          gap_at;
        int          gap_len;
        bit          hold;
        int          busy_cycles;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    req_t mq[$];
    req_t exp_req[$];
    wr_t  exp_wr[$];
    int   m_pending = 0;
    int   m_drain   = 0;
    int   gap_lo    = 0;
    int   gap_hi    = 0;
    bit   force_valid = 1'b0;
    int   wr_seen   = 0;
    int   tag_seen  = 0;

    logic              s_busy, s_en, s_wr, s_tag;
    logic [ADDR_W-1:0] s_addr;
    logic [WSEL_W-1:0] s_sel;
    logic [DATA_W-1:0] s_data;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C ^ {a[7:0], a[15:8]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: memory drives its return, outputs are checked mid-cycle,
    // then the reference model advances.
    task automatic step();
        req_t r;
        wr_t  w;
        bit   was_idle, e_busy, e_en, e_wr, e_tag;
        logic [15:0] b;
        if (mq.size() > 0 && mq[0].due <= cyc && !(cyc >= gap_lo && cyc < gap_hi)) begin
            r = mq.pop_front();
            mem_data_valid = 1'b1;
            mem_data       = mem_word(r.addr);
        end else begin
            mem_data_valid = force_valid;
            mem_data       = 16'($urandom);
        end
        #3;
        s_busy = fsm_busy; s_en = mem_en; s_addr = mem_addr; s_wr = write_data_arr;
        s_sel = word_sel; s_data = fill_data; s_tag = write_tag_arr;

        was_idle = rst_n && m_drain == 0 && m_pending == 0;
        e_busy   = !rst_n || m_drain > 0 || m_pending > 0 || miss_detected;
        e_en     = rst_n && exp_req.size() > 0 && exp_req[0].due == cyc;
        e_wr     = rst_n && m_pending > 0 && mem_data_valid;
        e_tag    = e_wr && m_pending == 1;

        chk("fsm_busy", 32'(s_busy), 32'(e_busy));
        chk("mem_en", 32'(s_en), 32'(e_en));
        if (e_en) begin
            r = exp_req.pop_front();
            if (s_en) chk("mem_addr", 32'(s_addr), 32'(r.addr));
        end
        chk("write_data_arr", 32'(s_wr), 32'(e_wr));
        if (e_wr) begin
            w = exp_wr.pop_front();
            if (s_wr) begin
                chk("word_sel", 32'(s_sel), 32'(w.idx));
                chk("fill_data", 32'(s_data), 32'(w.data));
            end
            m_pending--;
        end
        chk("write_tag_arr", 32'(s_tag), 32'(e_tag));

        if (s_en) mq.push_back('{s_addr, cyc + MEM_LAT});
        if (s_wr) wr_seen++;
        if (s_tag) tag_seen++;

        if (!rst_n) begin
            exp_req.delete();
            exp_wr.delete();
            m_pending = 0;
            m_drain   = MEM_LAT;
        end else if (m_drain > 0) begin
            m_drain--;
        end else if (was_idle && miss_detected) begin
            b = miss_addr & ~16'(BLK_BYTES - 1);
            for (int k = 0; k < WORDS_PER_BLK; k++) begin
                exp_req.push_back('{b + 16'(2 * k), cyc + 1 + k});
                exp_wr.push_back('{k, mem_word(b + 16'(2 * k))});
            end
            m_pending = WORDS_PER_BLK;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_fill(input logic [15:0] addr, input int gap_at, input int gap_len,
                            input bit hold, output int busy_cyc, output logic [15:0] first_addr);
        int w0;
        int t0;
        bit got_first;
        w0 = wr_seen;
        t0 = tag_seen;
        got_first  = 1'b0;
        first_addr = 16'h0;
        busy_cyc   = 0;
        gap_lo = cyc + gap_at;
        gap_hi = cyc + gap_at + gap_len;
        miss_detected = 1'b1;
        miss_addr     = addr;
        step();
        if (s_busy) busy_cyc++;
        for (int i = 0; i < 60; i++) begin
            miss_detected = hold && m_pending > 0;
            miss_addr     = 16'($urandom);
            step();
            if (s_en && !got_first) begin
                first_addr = s_addr;
                got_first  = 1'b1;
            end
            if (!s_busy) break;
            busy_cyc++;
        end
        miss_detected = 1'b0;
        chk("fill_word_writes", 32'(wr_seen - w0), 32'(WORDS_PER_BLK));
        chk("fill_tag_pulses", 32'(tag_seen - t0), 32'd1);
    endtask

    initial begin
        vec_t        vecs[5];
        int          bc;
        int          cnt;
        int          w1;
        int          t1;
        logic [15:0] fa;
        logic [15:0] ra;

        vecs[0] = '{16'h1236, 16'h1230, 0, 0, 1'b0, 13};
        vecs[1] = '{16'h1230, 16'h1230, 7, 2, 1'b0, 15};
        vecs[2] = '{16'hFFFA, 16'hFFF0, 0, 0, 1'b1, 13};
        vecs[3] = '{16'h0001, 16'h0000, 0, 0, 1'b0, 13};
        vecs[4] = '{16'hABCF, 16'hABC0, 5, 3, 1'b1, 16};

        rst_n = 1'b0;
        miss_detected = 1'b0;
        miss_addr = 16'h0;
        mem_data_valid = 1'b0;
        mem_data = 16'h0;
        @(posedge clk);
        #1;

        // Reset, then idle: busy only for the drain window.
        step();
        step();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_busy) cnt++;
        end
        chk("reset_drain_busy_cycles", 32'(cnt), 32'(MEM_LAT));

        // Table of single fills: alignment, gaps, top-of-memory block, held miss.
        foreach (vecs[i]) begin
            run_fill(vecs[i].addr, vecs[i].gap_at, vecs[i].gap_len, vecs[i].hold, bc, fa);
            chk("vec_first_req_addr", 32'(fa), 32'(vecs[i].base));
            chk("vec_busy_cycles", 32'(bc), 32'(vecs[i].busy_cycles));
            force_valid = 1'b1;
            step();
            force_valid = 1'b0;
            step();
        end

        // Reset one cycle after the third return of a fill.
        gap_lo = 0;
        gap_hi = 0;
        w1 = wr_seen;
        miss_detected = 1'b1;
        miss_addr = 16'h0100;
        step();
        miss_detected = 1'b0;
        for (int i = 0; i < 30 && (wr_seen - w1) < 3; i++) step();
        w1 = wr_seen;
        t1 = tag_seen;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!s_busy) break;
            cnt++;
        end
        chk("abort_drain_cycles", 32'(cnt), 32'(MEM_LAT));
        chk("abort_no_writes", 32'(wr_seen - w1), 32'd0);
        chk("abort_no_tag", 32'(tag_seen - t1), 32'd0);
        run_fill(16'h0040, 0, 0, 1'b0, bc, fa);
        chk("after_abort_base", 32'(fa), 32'h0040);
        chk("after_abort_busy", 32'(bc), 32'(WORDS_PER_BLK + MEM_LAT + 1));

        // Back-to-back: second miss in the first idle cycle after the tag pulse.
        miss_detected = 1'b1;
        miss_addr = 16'h2468;
        step();
        miss_detected = 1'b0;
        for (int i = 0; i < 40 && m_pending > 0; i++) step();
        run_fill(16'h7ABC, 0, 0, 1'b0, bc, fa);
        chk("b2b_second_base", 32'(fa), 32'h7AB0);
        chk("b2b_second_busy", 32'(bc), 32'(WORDS_PER_BLK + MEM_LAT + 1));

        // Random fills with random return gaps, held misses and stray valids in idle.
        for (int n = 0; n < 16; n++) begin
            ra = 16'($urandom);
            run_fill(ra, $urandom_range(1, 12), $urandom_range(0, 3), 1'($urandom_range(0, 1)), bc, fa);
            chk("rand_first_req_addr", 32'(fa), 32'(ra & 16'hFFF0));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                force_valid = 1'($urandom_range(0, 1));
                step();
            end
            force_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
